// File: rtl/framebuffer_write_arbiter_pkg.sv
// Shared widths, FSM encodings and helpers for the framebuffer port-A arbiter.
package framebuffer_write_arbiter_pkg;

    localparam int FB_ADDR_WIDTH = 12;
    localparam int FB_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        FBA_IDLE = 2'd0,
        FBA_FILL = 2'd1,
        FBA_DONE = 2'd2
    } fba_state_e;

    // Stall counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/framebuffer_write_arbiter_if.sv
// Port-A bus: UART-side request signals in, multimem port-A signals out.
interface framebuffer_write_arbiter_if
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] uart_address;
    logic [DATA_WIDTH-1:0] uart_data;
    logic                  uart_write_enable;
    logic                  uart_clk_enable;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  ram_write_enable;
    logic                  ram_clk_enable;

    // Driven by control_module (or a bench standing in for it).
    modport master (
        output uart_address, uart_data, uart_write_enable, uart_clk_enable,
        input  ram_address, ram_data_out, ram_write_enable, ram_clk_enable
    );

    // Driven by the arbiter.
    modport slave (
        input  uart_address, uart_data, uart_write_enable, uart_clk_enable,
        output ram_address, ram_data_out, ram_write_enable, ram_clk_enable
    );

endinterface

// File: rtl/framebuffer_write_arbiter_fill_sequencer.sv
// Fill engine: walks addresses 0..FILL_LAST_ADDR writing one byte, advancing
// only on cycles the top-level mux grants it; counts cycles lost to UART.
module fb_fill_sequencer
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = FB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = FB_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] FILL_LAST_ADDR = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fill_start_i,
    input  logic [DATA_WIDTH-1:0] fill_value_i,
    input  logic                  fill_gnt_i,
    output logic                  fill_req_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_value_o,
    output logic                  fill_busy_o,
    output logic                  fill_done_o,
    output logic [7:0]            fill_stall_count_o
);

    fba_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [7:0]            stall_q, stall_d;

    // State, address, value and stall-count registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FBA_IDLE;
            addr_q  <= '0;
            value_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic; a FILL cycle without grant means UART took the port.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        value_d = value_q;
        stall_d = stall_q;
        case (state_q)
            FBA_IDLE: begin
                if (fill_start_i) begin
                    value_d = fill_value_i;
                    addr_d  = '0;
                    stall_d = '0;
                    state_d = FBA_FILL;
                end
            end
            FBA_FILL: begin
                if (fill_gnt_i) begin
                    if (addr_q == FILL_LAST_ADDR) begin
                        state_d = FBA_DONE;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    stall_d = sat_inc8(stall_q);
                end
            end
            FBA_DONE: state_d = FBA_IDLE;
            default:  state_d = FBA_IDLE;
        endcase
    end

    assign fill_req_o         = (state_q == FBA_FILL);
    assign fill_busy_o        = (state_q == FBA_FILL);
    assign fill_done_o        = (state_q == FBA_DONE);
    assign fill_addr_o        = addr_q;
    assign fill_value_o       = value_q;
    assign fill_stall_count_o = stall_q;

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Framebuffer port-A arbiter: UART path has strict priority, the fill engine
// uses idle cycles. Both sources see one cycle of registered latency.
module framebuffer_write_arbiter
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = FB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = FB_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] FILL_LAST_ADDR = {ADDR_WIDTH{1'b1}}
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    framebuffer_write_arbiter_if.slave   bus,
    input  logic                         fill_start_i,
    input  logic [DATA_WIDTH-1:0]        fill_value_i,
    output logic                         fill_busy_o,
    output logic                         fill_done_o,
    output logic [7:0]                   fill_stall_count_o
);

    logic                  fill_req;
    logic                  fill_gnt;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_value;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  ce_q, ce_d;

    assign fill_gnt = fill_req & ~bus.uart_clk_enable;

    fb_fill_sequencer #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .FILL_LAST_ADDR (FILL_LAST_ADDR)
    ) u_seq (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .fill_start_i       (fill_start_i),
        .fill_value_i       (fill_value_i),
        .fill_gnt_i         (fill_gnt),
        .fill_req_o         (fill_req),
        .fill_addr_o        (fill_addr),
        .fill_value_o       (fill_value),
        .fill_busy_o        (fill_busy_o),
        .fill_done_o        (fill_done_o),
        .fill_stall_count_o (fill_stall_count_o)
    );

    // Priority mux: UART, then fill; with no request address/data hold.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        we_d   = 1'b0;
        ce_d   = 1'b0;
        if (bus.uart_clk_enable) begin
            addr_d = bus.uart_address;
            data_d = bus.uart_data;
            we_d   = bus.uart_write_enable;
            ce_d   = 1'b1;
        end else if (fill_gnt) begin
            addr_d = fill_addr;
            data_d = fill_value;
            we_d   = 1'b1;
            ce_d   = 1'b1;
        end
    end

    // Port-A output registers, all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
            ce_q   <= ce_d;
        end
    end

    assign bus.ram_address      = addr_q;
    assign bus.ram_data_out     = data_q;
    assign bus.ram_write_enable = we_q;
    assign bus.ram_clk_enable   = ce_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Directed bench for framebuffer_write_arbiter: vector table plus fill sequences.
module tb_framebuffer_write_arbiter;
    import framebuffer_write_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       fill_start;
    logic [7:0] fill_value;
    logic       fill_busy;
    logic       fill_done;
    logic [7:0] fill_stall_count;

    always #5 clk = ~clk;

    framebuffer_write_arbiter_if bus ();

    framebuffer_write_arbiter dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .bus                (bus),
        .fill_start_i       (fill_start),
        .fill_value_i       (fill_value),
        .fill_busy_o        (fill_busy),
        .fill_done_o        (fill_done),
        .fill_stall_count_o (fill_stall_count)
    );

    typedef struct {
        logic        uce;
        logic        uwe;
        logic [11:0] ua;
        logic [7:0]  ud;
        logic        fs;
        logic [7:0]  fv;
        logic        ece;
        logic        ewe;
        logic [11:0] ea;
        logic [7:0]  ed;
        logic        ebusy;
        logic        edone;
        logic [7:0]  estall;
    } vec_t;

    vec_t tbl [10];
    logic [7:0] exp_mem [4096];
    logic [7:0] obs_mem [4096];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic uart_idle();
        bus.uart_clk_enable   = 1'b0;
        bus.uart_write_enable = 1'b0;
        bus.uart_address      = 12'h000;
        bus.uart_data         = 8'h00;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        uart_idle();
        fill_start = 1'b0;
        fill_value = 8'h00;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    // Full fill with optional UART intrusions and an optional ignored restart.
    task automatic do_fill(input string tag, input logic [7:0] val, input int n_uart,
                           input int restart_cyc);
        int  exp_addr;
        int  bad;
        int  trail_bad;
        int  memerr;
        int  cyc;
        int  k;
        bit  finished;
        bit  uon;
        logic [7:0] ud;
        exp_addr = 0; bad = 0; trail_bad = 0; memerr = 0; cyc = 0; k = 0;
        finished = 1'b0; ud = 8'h00;
        for (int i = 0; i < 4096; i++) begin
            exp_mem[i] = 8'hEE;
            obs_mem[i] = 8'hEE;
        end
        uart_idle();
        fill_start = 1'b1;
        fill_value = val;
        step();
        fill_start = 1'b0;
        fill_value = 8'h00;
        check({tag, "_busy_at_start"}, {31'd0, fill_busy}, 32'd1);
        check({tag, "_stall_cleared"}, {24'd0, fill_stall_count}, 32'd0);
        while (!finished && cyc < 6000) begin
            uon = (k < n_uart) && (cyc % 700 == 350);
            if (uon) begin
                ud = 8'h5A + 8'(k);
                bus.uart_clk_enable   = 1'b1;
                bus.uart_write_enable = 1'b1;
                bus.uart_address      = 12'h010;
                bus.uart_data         = ud;
            end else begin
                uart_idle();
            end
            if (cyc == restart_cyc) begin
                fill_start = 1'b1;
                fill_value = 8'hFF;
            end else begin
                fill_start = 1'b0;
                fill_value = 8'h00;
            end
            step();
            if (bus.ram_clk_enable === 1'b1 && bus.ram_write_enable === 1'b1)
                obs_mem[bus.ram_address] = bus.ram_data_out;
            if (uon) begin
                if (!(bus.ram_clk_enable === 1'b1 && bus.ram_write_enable === 1'b1 &&
                      bus.ram_address === 12'h010 && bus.ram_data_out === ud &&
                      fill_done === 1'b0 && fill_busy === 1'b1)) bad++;
                exp_mem[12'h010] = ud;
                k++;
            end else begin
                if (!(bus.ram_clk_enable === 1'b1 && bus.ram_write_enable === 1'b1 &&
                      bus.ram_address === 12'(exp_addr) && bus.ram_data_out === val)) bad++;
                exp_mem[exp_addr] = val;
                if (exp_addr == 4095) begin
                    if (!(fill_done === 1'b1 && fill_busy === 1'b0)) bad++;
                    finished = 1'b1;
                end else if (!(fill_done === 1'b0 && fill_busy === 1'b1)) begin
                    bad++;
                end
                exp_addr++;
            end
            cyc++;
        end
        uart_idle();
        fill_start = 1'b0;
        check({tag, "_completed_in_budget"}, {31'd0, finished}, 32'd1);
        check({tag, "_write_sequence_errors"}, 32'(bad), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (!(fill_done === 1'b0 && fill_busy === 1'b0 && bus.ram_clk_enable === 1'b0 &&
                  bus.ram_write_enable === 1'b0)) trail_bad++;
        end
        check({tag, "_after_done_errors"}, 32'(trail_bad), 32'd0);
        check({tag, "_stall_count_held"}, {24'd0, fill_stall_count}, 32'(n_uart));
        for (int i = 0; i < 4096; i++)
            if (obs_mem[i] !== exp_mem[i]) memerr++;
        check({tag, "_ram_image_errors"}, 32'(memerr), 32'd0);
    endtask

    initial begin
        int guard;
        //          uce  uwe  ua      ud     fs   fv     ece  ewe  ea      ed     busy done stall
        tbl[0] = '{1'b0,1'b0,12'h000,8'h00,1'b0,8'h00, 1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,8'h00};
        tbl[1] = '{1'b1,1'b1,12'h123,8'hA5,1'b0,8'h00, 1'b1,1'b1,12'h123,8'hA5,1'b0,1'b0,8'h00};
        tbl[2] = '{1'b0,1'b0,12'h000,8'h00,1'b0,8'h00, 1'b0,1'b0,12'h123,8'hA5,1'b0,1'b0,8'h00};
        tbl[3] = '{1'b1,1'b0,12'h456,8'h11,1'b0,8'h00, 1'b1,1'b0,12'h456,8'h11,1'b0,1'b0,8'h00};
        tbl[4] = '{1'b0,1'b1,12'h789,8'h22,1'b0,8'h00, 1'b0,1'b0,12'h456,8'h11,1'b0,1'b0,8'h00};
        tbl[5] = '{1'b1,1'b1,12'h010,8'h77,1'b1,8'h3C, 1'b1,1'b1,12'h010,8'h77,1'b1,1'b0,8'h00};
        tbl[6] = '{1'b0,1'b0,12'h000,8'h00,1'b0,8'h00, 1'b1,1'b1,12'h000,8'h3C,1'b1,1'b0,8'h00};
        tbl[7] = '{1'b1,1'b1,12'h020,8'h55,1'b1,8'hFF, 1'b1,1'b1,12'h020,8'h55,1'b1,1'b0,8'h01};
        tbl[8] = '{1'b0,1'b0,12'h000,8'h00,1'b0,8'h00, 1'b1,1'b1,12'h001,8'h3C,1'b1,1'b0,8'h01};
        tbl[9] = '{1'b0,1'b0,12'h000,8'h00,1'b0,8'h00, 1'b1,1'b1,12'h002,8'h3C,1'b1,1'b0,8'h01};

        do_reset(3);
        check("reset_ce",    {31'd0, bus.ram_clk_enable},   32'd0);
        check("reset_we",    {31'd0, bus.ram_write_enable}, 32'd0);
        check("reset_addr",  {20'd0, bus.ram_address},      32'd0);
        check("reset_data",  {24'd0, bus.ram_data_out},     32'd0);
        check("reset_busy",  {31'd0, fill_busy},            32'd0);
        check("reset_done",  {31'd0, fill_done},            32'd0);
        check("reset_stall", {24'd0, fill_stall_count},     32'd0);

        for (int i = 0; i < 10; i++) begin
            bus.uart_clk_enable   = tbl[i].uce;
            bus.uart_write_enable = tbl[i].uwe;
            bus.uart_address      = tbl[i].ua;
            bus.uart_data         = tbl[i].ud;
            fill_start            = tbl[i].fs;
            fill_value            = tbl[i].fv;
            step();
            check($sformatf("vec%0d_ce", i),    {31'd0, bus.ram_clk_enable},   {31'd0, tbl[i].ece});
            check($sformatf("vec%0d_we", i),    {31'd0, bus.ram_write_enable}, {31'd0, tbl[i].ewe});
            check($sformatf("vec%0d_addr", i),  {20'd0, bus.ram_address},      {20'd0, tbl[i].ea});
            check($sformatf("vec%0d_data", i),  {24'd0, bus.ram_data_out},     {24'd0, tbl[i].ed});
            check($sformatf("vec%0d_busy", i),  {31'd0, fill_busy},            {31'd0, tbl[i].ebusy});
            check($sformatf("vec%0d_done", i),  {31'd0, fill_done},            {31'd0, tbl[i].edone});
            check($sformatf("vec%0d_stall", i), {24'd0, fill_stall_count},     {24'd0, tbl[i].estall});
        end

        do_reset(1);
        check("abort_table_fill_busy", {31'd0, fill_busy}, 32'd0);

        do_fill("fill00", 8'h00, 0, -1);
        do_fill("fill3c_uart", 8'h3C, 5, -1);
        do_fill("fill81_restart", 8'h81, 0, 2000);

        // Stall counter saturation while UART holds the port continuously.
        do_reset(1);
        fill_start = 1'b1;
        fill_value = 8'h99;
        step();
        fill_start = 1'b0;
        bus.uart_clk_enable = 1'b1;
        for (int i = 0; i < 254; i++) step();
        check("sat_stall_fe", {24'd0, fill_stall_count}, 32'h0FE);
        for (int i = 0; i < 46; i++) step();
        check("sat_stall_ff", {24'd0, fill_stall_count}, 32'h0FF);
        check("sat_busy", {31'd0, fill_busy}, 32'd1);
        uart_idle();
        step();
        check("sat_first_fill_addr", {20'd0, bus.ram_address}, 32'd0);
        check("sat_first_fill_data", {24'd0, bus.ram_data_out}, 32'h099);
        check("sat_first_fill_ce", {31'd0, bus.ram_clk_enable}, 32'd1);

        // Reset in the middle of a fill, at fill address 0x400.
        do_reset(1);
        fill_start = 1'b1;
        fill_value = 8'h42;
        step();
        fill_start = 1'b0;
        guard = 0;
        while (!(bus.ram_clk_enable === 1'b1 && bus.ram_address === 12'h3FF) && guard < 2000) begin
            step();
            guard++;
        end
        check("abort_reached_3ff", {31'd0, (guard < 2000)}, 32'd1);
        reset = 1'b1;
        step();
        check("abort_busy", {31'd0, fill_busy}, 32'd0);
        check("abort_ce",   {31'd0, bus.ram_clk_enable}, 32'd0);
        check("abort_we",   {31'd0, bus.ram_write_enable}, 32'd0);
        check("abort_done", {31'd0, fill_done}, 32'd0);
        reset = 1'b0;
        step();
        check("abort_post_done", {31'd0, fill_done}, 32'd0);
        check("abort_post_busy", {31'd0, fill_busy}, 32'd0);
        check("abort_post_ce",   {31'd0, bus.ram_clk_enable}, 32'd0);
        fill_start = 1'b1;
        fill_value = 8'h24;
        step();
        fill_start = 1'b0;
        check("restart_busy", {31'd0, fill_busy}, 32'd1);
        step();
        check("restart_addr0", {20'd0, bus.ram_address}, 32'd0);
        check("restart_data",  {24'd0, bus.ram_data_out}, 32'h024);
        check("restart_ce",    {31'd0, bus.ram_clk_enable}, 32'd1);
        step();
        check("restart_addr1", {20'd0, bus.ram_address}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
